// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester arbiter/sequencer for one fixed-latency memory port.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module mem_port_arbiter #(
  parameter int n = 32,
  parameter int MEM_LAT = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req0,
  input  logic         req1,
  input  logic         we0,
  input  logic         we1,
  input  logic [n-1:0] addr0,
  input  logic [n-1:0] addr1,
  input  logic [n-1:0] wdata0,
  input  logic [n-1:0] wdata1,
  output logic         sel,
  output logic         mem_en,
  output logic         mem_we,
  output logic [n-1:0] mem_addr,
  output logic [n-1:0] mem_wdata,
  input  logic [n-1:0] mem_rdata,
  output logic         done0,
  output logic         done1,
  output logic [n-1:0] rdata
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t     state;
  logic [3:0] cnt;
  logic       win;
`ifdef MEM_ARB_FIXED_PRIO_EN
  assign win = !req0;
`else
  logic prio;
  assign win = (req0 && req1) ? prio : req1;
`endif
  assign mem_addr  = sel ? addr1 : addr0;
  assign mem_wdata = sel ? wdata1 : wdata0;
  // write enable only reaches the port while an access is actually running
  assign mem_we    = mem_en && (sel ? we1 : we0);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      sel    <= 1'b0;
      cnt    <= 4'd0;
      rdata  <= '0;
      mem_en <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      prio   <= 1'b0;
`endif
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: if (req0 || req1) begin
          sel    <= win;
          cnt    <= 4'(MEM_LAT - 1);
          mem_en <= 1'b1;
          state  <= BUSY;
`ifndef MEM_ARB_FIXED_PRIO_EN
          prio   <= !win;
`endif
        end
        BUSY: if (cnt == 4'd0) begin
          rdata  <= mem_rdata;
          mem_en <= 1'b0;
          done0  <= !sel;
          done1  <= sel;
          state  <= DONE;
        end else begin
          cnt <= cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench with a completion scoreboard; dut uses MEM_LAT=2, dut_b MEM_LAT=1.
module tb_mem_port_arbiter;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0, mem_rdata = '0;
  logic        sel, mem_en, mem_we, done0, done1;
  logic [31:0] mem_addr, mem_wdata, rdata;
  logic        sel_b, mem_en_b, mem_we_b, done0_b, done1_b;
  logic [31:0] mem_addr_b, mem_wdata_b, rdata_b;
  int passed = 0, total = 0, fails = 0;
  typedef struct {logic who; logic [31:0] data;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  logic exp_who [4];

  mem_port_arbiter #(.n(32), .MEM_LAT(2)) dut (
    .clk(clk), .reset_n(reset_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .sel(sel), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .done0(done0), .done1(done1), .rdata(rdata));

  mem_port_arbiter #(.n(32), .MEM_LAT(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .sel(sel_b), .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata), .done0(done0_b), .done1(done1_b), .rdata(rdata_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (done0 || done1) begin
      chk("done_onehot", 64'(done0 && done1), 64'd0);
      if (exp_q.size() == 0) chk("sb_pending", 64'(exp_q.size()), 64'd1);
      else begin
        e = exp_q.pop_front();
        chk("sb_who", 64'(done1), 64'(e.who));
        chk("sb_rdata", 64'(rdata), 64'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; addr0 = 32'h5A;
    tick(); tick();
    chk("rst_sel", 64'(sel), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_done0", 64'(done0), 64'd0);
    chk("rst_done1", 64'(done1), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'h5A);
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; reset_n = 1'b1;
    tick();
    // single read from requester 0
    req0 = 1'b1; addr0 = 32'h40;
    exp_q.push_back('{1'b0, 32'hDEADBEEF});
    tick();
    chk("rd_mem_en1", 64'(mem_en), 64'd1);
    chk("rd_sel", 64'(sel), 64'd0);
    chk("rd_mem_addr", 64'(mem_addr), 64'h40);
    chk("rd_mem_we", 64'(mem_we), 64'd0);
    mem_rdata = 32'hDEADBEEF;
    tick();
    chk("rd_mem_en2", 64'(mem_en), 64'd1);
    chk("rd_done_early", 64'(done0), 64'd0);
    tick();
    chk("rd_done0", 64'(done0), 64'd1);
    chk("rd_mem_en_off", 64'(mem_en), 64'd0);
    req0 = 1'b0;
    tick();
    chk("rd_done0_pulse", 64'(done0), 64'd0);
    // simultaneous requests straight after reset
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1; mem_rdata = 32'hCAFE0001;
    req0 = 1'b1; addr0 = 32'h100;
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h80; wdata1 = 32'h12345678;
    exp_q.push_back('{1'b0, 32'hCAFE0001});
    exp_q.push_back('{1'b1, 32'hCAFE0001});
    tick();
    chk("sim_sel0", 64'(sel), 64'd0);
    chk("sim_mem_en0", 64'(mem_en), 64'd1);
    tick(); tick();
    chk("sim_done0", 64'(done0), 64'd1);
    req0 = 1'b0;
    tick();
    chk("sim_gap_mem_en", 64'(mem_en), 64'd0);
    chk("sim_gap_sel", 64'(sel), 64'd0);
    tick();
    chk("sim_sel1", 64'(sel), 64'd1);
    chk("sim_mem_en1", 64'(mem_en), 64'd1);
    chk("sim_mem_we1", 64'(mem_we), 64'd1);
    chk("sim_mem_addr1", 64'(mem_addr), 64'h80);
    chk("sim_mem_wdata1", 64'(mem_wdata), 64'h12345678);
    tick(); tick();
    chk("sim_done1", 64'(done1), 64'd1);
    req1 = 1'b0; we1 = 1'b0;
    tick();
    // both requests held for four back-to-back transactions
`ifdef MEM_ARB_FIXED_PRIO_EN
    exp_who = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_who = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mem_rdata = 32'h10000000 + 32'(k);
      exp_q.push_back('{exp_who[k], 32'h10000000 + 32'(k)});
      tick();
      chk($sformatf("rr_sel%0d", k), 64'(sel), 64'(exp_who[k]));
      chk($sformatf("rr_mem_en%0d", k), 64'(mem_en), 64'd1);
      tick(); tick();
      if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
      tick();
    end
    // requester 1 drops its request mid-transfer
    req1 = 1'b1; addr1 = 32'h200; mem_rdata = 32'hBEEF0002;
    exp_q.push_back('{1'b1, 32'hBEEF0002});
    tick();
    chk("drop_sel", 64'(sel), 64'd1);
    req1 = 1'b0;
    tick(); tick();
    chk("drop_done1", 64'(done1), 64'd1);
    tick();
    chk("drop_done1_once", 64'(done1), 64'd0);
    tick();
    chk("drop_no_restart", 64'(mem_en), 64'd0);
    // reset in the first BUSY cycle drops the transaction
    req0 = 1'b1; addr0 = 32'h300; mem_rdata = 32'h77777777;
    tick();
    chk("abort_mem_en", 64'(mem_en), 64'd1);
    reset_n = 1'b0;
    tick();
    chk("abort_mem_en_off", 64'(mem_en), 64'd0);
    chk("abort_done0", 64'(done0), 64'd0);
    chk("abort_sel", 64'(sel), 64'd0);
    chk("abort_rdata", 64'(rdata), 64'd0);
    req0 = 1'b0; reset_n = 1'b1;
    tick(); tick(); tick();
    chk("abort_no_done", 64'(done0 || done1), 64'd0);
    // MEM_LAT=1 read from requester 1 (dut sees it too, with its longer latency)
    req1 = 1'b1; addr1 = 32'h44; mem_rdata = 32'h0BADF00D;
    exp_q.push_back('{1'b1, 32'h0BADF00D});
    tick();
    chk("lat1_mem_en", 64'(mem_en_b), 64'd1);
    chk("lat1_sel", 64'(sel_b), 64'd1);
    chk("lat1_mem_addr", 64'(mem_addr_b), 64'h44);
    chk("lat1_done_early", 64'(done1_b), 64'd0);
    tick();
    chk("lat1_mem_en_off", 64'(mem_en_b), 64'd0);
    chk("lat1_done1", 64'(done1_b), 64'd1);
    chk("lat1_rdata", 64'(rdata_b), 64'h0BADF00D);
    req1 = 1'b0;
    tick();
    chk("lat1_done1_pulse", 64'(done1_b), 64'd0);
    tick(); tick();
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Two-requester arbiter and sequencer for a single shared memory port.
- Sits between instruction fetch (requester 0) and the MEM stage (requester 1).
- Owns the `sel` line of the `n`-bit `mux_n` instances that steer address and write data onto the port, and runs a fixed-latency access per grant.
- Returns the read data and a one-cycle completion pulse to the winning requester.

## Interface
Parameters:
- `n`, 32, data and address width; must match the `n` of the steering `mux_n` instances.
- `MEM_LAT`, 2, memory access cycles per transaction; legal range 1..15.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `req0` / `req1`  in  1  access request from requester 0 / 1.
- `we0` / `we1`  in  1  write enable accompanying `req0` / `req1`.
- `addr0` / `addr1`  in  n  request address.
- `wdata0` / `wdata1`  in  n  write data.
- `sel`  out  1  mux select; 0 steers requester 0, 1 steers requester 1.
- `mem_en`  out  1  port access strobe.
- `mem_we`  out  1  port write enable (the granted requester's `we`).
- `mem_addr`  out  n  muxed address.
- `mem_wdata`  out  n  muxed write data.
- `mem_rdata`  in  n  port read data; valid at the end of the last `mem_en` cycle.
- `done0` / `done1`  out  1  one-cycle completion pulse to requester 0 / 1.
- `rdata`  out  n  registered read data; valid while `done0` or `done1` is high.

## Operation
State machine: IDLE, BUSY, DONE.

IDLE:
- `mem_en` = 0.
- If any `req` is sampled high: latch the winner into `sel`, load `cnt` = `MEM_LAT`-1, go to BUSY.

Arbitration:
- A single request wins outright.
- If both are high, grant `prio`.
- Every grant to requester x sets `prio` = !x.

BUSY:
- `mem_en` = 1.
- `mem_we` = `sel` ? `we1` : `we0`.
- `mem_addr` and `mem_wdata` are the combinational mux of the inputs through `sel`.
- `cnt` decrements each cycle. When `cnt` = 0: capture `mem_rdata` into `rdata` and go to DONE.

DONE:
- `done[sel]` = 1 for exactly one cycle, then go to IDLE.
- For a write transaction, `rdata` holds the last captured read value.

Requester rules:
- Requester holds `req`, `we`, `addr` and `wdata` stable until its `done`.
- Deasserting `req` during BUSY does not abort the transfer; it completes and `done` still pulses.
- Requester must drop `req` in the `done` cycle. A `req` still high in the following IDLE cycle starts a new transaction.

No overlap:
- One transaction at a time.
- A request arriving during BUSY or DONE waits for IDLE.

Reset (`reset_n` low at a rising edge, from any state, including mid-BUSY):
- State goes to IDLE and the current transaction is dropped; no `done` pulse.
- `sel` = 0, `prio` = 0, `cnt` = 0, `rdata` = 0.
- `mem_en` = 0, `mem_we` = 0, `done0` = `done1` = 0.
- `mem_addr` / `mem_wdata` follow the requester-0 inputs, since `sel` = 0.

## Timing
Request sampled in IDLE at edge t:
- BUSY and `mem_en` = 1 for cycles t+1 .. t+`MEM_LAT`.
- `mem_rdata` is captured at the end of cycle t+`MEM_LAT`.
- `done` and `rdata` are valid in cycle t+`MEM_LAT`+1 (DONE).
- IDLE in cycle t+`MEM_LAT`+2.

Throughput and outputs:
- Total latency from request to `done` = `MEM_LAT`+1 cycles.
- Minimum spacing between grants = `MEM_LAT`+2 cycles.
- `sel` changes only on the IDLE→BUSY edge and is stable through BUSY and DONE.
- `done0`, `done1`, `rdata`, `sel`, `mem_en` are registered. `mem_addr`, `mem_wdata`, `mem_we` are combinational from `sel`.

## Configuration
- `MEM_ARB_FIXED_PRIO_EN` defined:
  - Requester 0 always wins a simultaneous request.
  - The `prio` register is not built.
  - Requester 1 can starve.
- Undefined (default): round-robin via `prio` as described above.

## Test plan
- **Reset values:** hold `reset_n` = 0 for 2 cycles with `req0` = `req1` = 1 -> `sel` = 0, `mem_en` = 0, `done0` = `done1` = 0, `rdata` = 0.
- **Single read:** `MEM_LAT` = 2, `req0` = 1, `addr0` = 0x00000040, `mem_rdata` = 0xDEADBEEF on the second BUSY cycle -> `mem_en` high 2 cycles, `mem_addr` = 0x40, `done0` pulses 3 cycles after the request edge, `rdata` = 0xDEADBEEF.
- **Simultaneous requests:** both requests high after reset and held until each `done`, `req1` with `we1` = 1, `addr1` = 0x80, `wdata1` = 0x12345678 -> requester 0 served first (`sel` = 0, `done0`). Requester 1 then serves (`sel` = 1, `mem_we` = 1, `mem_addr` = 0x80, `mem_wdata` = 0x12345678, `done1`) with its grant edge 4 cycles after requester 0's.
- **Round-robin:** both requests asserted continuously for 4 transactions -> grant order 0,1,0,1. With `MEM_ARB_FIXED_PRIO_EN` defined, order is 0,0,0,0.
- **Mid-transfer:** `req1` dropped during BUSY -> transaction completes and `done1` pulses once. Separately, `reset_n` = 0 in the first BUSY cycle -> IDLE next cycle, no `done` pulse, `mem_en` = 0.
- **Minimum latency:** `MEM_LAT` = 1, `req1` read -> `mem_en` high for 1 cycle, `done1` 2 cycles after the request edge.
